// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the PSRAM controller port between two masters, one transaction at a time,
// with round-robin or fixed priority and a watchdog that forces completion with ERR_DATA.
module mem_arbiter #(
   parameter bit          PRIO0          = 1'b0,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] m0_a,
   input  logic [31:0] m0_d,
   input  logic        m0_we,
   input  logic        m0_rd,
   output logic [31:0] m0_spo,
   output logic        m0_ready,
   input  logic [31:0] m1_a,
   input  logic [31:0] m1_d,
   input  logic        m1_we,
   input  logic        m1_rd,
   output logic [31:0] m1_spo,
   output logic        m1_ready,
   output logic [31:0] s_a,
   output logic [31:0] s_d,
   output logic        s_we,
   output logic        s_rd,
   input  logic [31:0] s_spo,
   input  logic        s_ready,
   output logic [1:0]  grant,
   output logic        irq
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   logic [1:0] state;
   logic owner, last_grant, lat_we, lat_rd, timed_out;
   logic [31:0] lat_a, lat_d, data;
   logic [CW-1:0] cnt;
   logic req0, req1, win, expire;
   assign req0 = m0_we | m0_rd;
   assign req1 = m1_we | m1_rd;
   // Tie goes to m0 under fixed priority, otherwise to whoever did not win last
   assign win = (req0 & req1) ? (PRIO0 ? 1'b0 : ~last_grant) : req1;
   assign expire = cnt == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         lat_we     <= 1'b0;
         lat_rd     <= 1'b0;
         lat_a      <= '0;
         lat_d      <= '0;
         data       <= '0;
         cnt        <= '0;
         timed_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req0 | req1) begin
               owner      <= win;
               last_grant <= win;
               lat_a      <= win ? m1_a : m0_a;
               lat_d      <= win ? m1_d : m0_d;
               lat_we     <= win ? m1_we : m0_we;
               lat_rd     <= win ? m1_rd : m0_rd;
               cnt        <= '0;
               timed_out  <= 1'b0;
               state      <= BUSY;
            end
            BUSY: if (s_ready) begin
               data  <= s_spo;
               state <= DONE;
            end else if (expire) begin
               data      <= ERR_DATA;
               timed_out <= 1'b1;
               state     <= DONE;
            end else begin
               cnt <= cnt + CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
   // Strobes and handshakes decode from state so an async reset drops them at once
   assign s_a      = lat_a;
   assign s_d      = lat_d;
   assign s_we     = state == BUSY && lat_we;
   assign s_rd     = state == BUSY && lat_rd && !lat_we;
   assign grant    = state == IDLE ? 2'b00 : (owner ? 2'b10 : 2'b01);
   assign m0_ready = state == DONE && !owner;
   assign m1_ready = state == DONE && owner;
   assign m0_spo   = m0_ready ? data : '0;
   assign m1_spo   = m1_ready ? data : '0;
   assign irq      = state == DONE && timed_out;
endmodule
